// File: rtl/pwm_capture_pkg.sv
// pwm_pkg: shared types and default count geometry for the PWM generator /
// capture pair. Optional deglitch filter in the capture path: PWM_DEGLITCH_EN.
package pwm_pkg;

    // Default time base, shared with the generator so loopback counts match.
    localparam int WIDTH_COUNT   = 14;
    localparam int CNT_MAX_COUNT = 10000;

    // Measurement FSM states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

endpackage

// File: rtl/pwm_capture_if.sv
// pwm_capture_if: measurement report bus (duty/period/valid/timeout).
// The capture block drives it through the master modport; consumers use slave.
// Optional deglitch filter in the capture path: PWM_DEGLITCH_EN.
interface pwm_capture_if #(
    parameter int widthCount = 14
);
    logic [widthCount-1:0] duty;
    logic [widthCount-1:0] period;
    logic                  valid;
    logic                  timeout;

    modport master (output duty, output period, output valid, output timeout);
    modport slave  (input  duty, input  period, input  valid, input  timeout);
endinterface

// File: rtl/pwm_capture_edge_sync.sv
// pwm_edge_sync: 2-flop synchronizer for the PWM input, optional deglitch
// filter (PWM_DEGLITCH_EN), and e-tick edge detection producing rise/fall.
// Without the filter the synchronizer output is the level directly, so a
// single-tick pulse is still seen as an edge pair.
module pwm_edge_sync #(
    parameter int FILT_LEN = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic rst_syn,
    input  logic e,
    input  logic pwmin,
    output logic lvl,
    output logic rise,
    output logic fall
);

    logic [1:0] sync_q;
    logic       prev_q;

    // Two-flop synchronizer, clocked every clk regardless of e.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)         sync_q <= '0;
        else if (rst_syn) sync_q <= '0;
        else              sync_q <= {sync_q[0], pwmin};
    end

`ifdef PWM_DEGLITCH_EN
    localparam int CW = $clog2(FILT_LEN + 1);
    localparam logic [CW-1:0] LAST = CW'(FILT_LEN - 1);

    logic [CW-1:0] flt_cnt;
    logic          flt_lvl;

    // Level follows the input only after FILT_LEN consecutive e-ticks of the
    // new value; both edges see the same delay so duty/period are preserved.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            flt_cnt <= '0;
            flt_lvl <= 1'b0;
        end else if (rst_syn) begin
            flt_cnt <= '0;
            flt_lvl <= 1'b0;
        end else if (e) begin
            if (sync_q[1] == flt_lvl) begin
                flt_cnt <= '0;
            end else if (flt_cnt == LAST) begin
                flt_lvl <= sync_q[1];
                flt_cnt <= '0;
            end else begin
                flt_cnt <= flt_cnt + CW'(1);
            end
        end
    end

    assign lvl = flt_lvl;
`else
    assign lvl = sync_q[1];
`endif

    // Previous level advances only on e-ticks so edges are in tick time.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)         prev_q <= 1'b0;
        else if (rst_syn) prev_q <= 1'b0;
        else if (e)       prev_q <= lvl;
    end

    assign rise = lvl & ~prev_q;
    assign fall = ~lvl & prev_q;

endmodule

// File: rtl/pwm_capture.sv
// pwm_capture: measures high time and period of an incoming PWM waveform in
// e-ticks. First rise after reset/timeout arms; each later rise reports.
// No qualifying edge for cntMaxCount ticks reports a timeout (0%/100% duty).
// Optional deglitch filter on the input level: PWM_DEGLITCH_EN.
module pwm_capture
    import pwm_pkg::*;
#(
    parameter int widthCount  = WIDTH_COUNT,
    parameter int cntMaxCount = CNT_MAX_COUNT,
    parameter int FILT_LEN    = 3
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           rst_syn,
    input  logic           e,
    input  logic           pwmin,
    pwm_capture_if.master  rpt
);

    localparam logic [widthCount-1:0] MAXC = widthCount'(cntMaxCount);
    localparam logic [widthCount-1:0] ONE  = widthCount'(1);

    logic                  lvl, rise, fall;
    state_t                state, state_nx;
    logic [widthCount-1:0] hi_cnt, per_cnt;
    logic                  edge_hit, at_max, meas, tmo;

    pwm_edge_sync #(.FILT_LEN(FILT_LEN)) u_edge (
        .clk     (clk),
        .rst     (rst),
        .rst_syn (rst_syn),
        .e       (e),
        .pwmin   (pwmin),
        .lvl     (lvl),
        .rise    (rise),
        .fall    (fall)
    );

    // The edge that moves each state forward; a HIGH->LOW fall can leave
    // per_cnt at MAXC+1, hence the >= so LOW still times out.
    assign edge_hit = (state == HIGH) ? fall : rise;
    assign at_max   = (per_cnt >= MAXC);

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)         state <= IDLE;
        else if (rst_syn) state <= IDLE;
        else              state <= state_nx;
    end

    // Next state: edges advance, timeout falls back to IDLE; edge wins a tie.
    always_comb begin
        state_nx = state;
        if (e) begin
            case (state)
                IDLE:    if (rise) state_nx = HIGH;
                HIGH:    if (fall) state_nx = LOW;  else if (at_max) state_nx = IDLE;
                LOW:     if (rise) state_nx = HIGH; else if (at_max) state_nx = IDLE;
                default: state_nx = IDLE;
            endcase
        end
    end

    // Decodes: a completed measurement or a timeout on this e-tick.
    always_comb begin
        meas = e & (state == LOW) & rise;
        tmo  = e & at_max & ~edge_hit;
    end

    // High-time and period counters, in e-ticks.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hi_cnt  <= '0;
            per_cnt <= '0;
        end else if (rst_syn) begin
            hi_cnt  <= '0;
            per_cnt <= '0;
        end else if (e) begin
            if (tmo) begin
                hi_cnt  <= '0;
                per_cnt <= '0;
            end else begin
                case (state)
                    IDLE, LOW: begin
                        if (rise) begin
                            hi_cnt  <= ONE;
                            per_cnt <= ONE;
                        end else begin
                            per_cnt <= per_cnt + ONE;
                        end
                    end
                    HIGH: begin
                        if (!fall) hi_cnt <= hi_cnt + ONE;
                        per_cnt <= per_cnt + ONE;
                    end
                    default: begin
                        hi_cnt  <= '0;
                        per_cnt <= '0;
                    end
                endcase
            end
        end
    end

    // Report registers: hold until the next measurement or timeout.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rpt.duty    <= '0;
            rpt.period  <= '0;
            rpt.valid   <= 1'b0;
            rpt.timeout <= 1'b0;
        end else if (rst_syn) begin
            rpt.duty    <= '0;
            rpt.period  <= '0;
            rpt.valid   <= 1'b0;
            rpt.timeout <= 1'b0;
        end else begin
            rpt.valid <= meas | tmo;
            if (meas) begin
                rpt.duty    <= hi_cnt;
                rpt.period  <= per_cnt;
                rpt.timeout <= 1'b0;
            end else if (tmo) begin
                rpt.duty    <= lvl ? MAXC : '0;
                rpt.period  <= MAXC;
                rpt.timeout <= 1'b1;
            end
        end
    end

endmodule
